// File: rtl/rs232tx_if.sv
// Bus-side port group of the buffered serial transmitter: write strobe and data
// in, FIFO status out.
interface rs232tx_if #(
   parameter int FIFO_LOG2 = 4
) ();
   logic [7:0]         transmit_data;
   logic               we;
   logic               clear_overrun;
   logic               busy;
   logic               full;
   logic [FIFO_LOG2:0] level;
   logic               overrun;

   modport master (
      output transmit_data, we, clear_overrun,
      input  busy, full, level, overrun
   );

   modport slave (
      input  transmit_data, we, clear_overrun,
      output busy, full, level, overrun
   );
endinterface

// File: rtl/rs232tx.sv
// Buffered serial transmitter: bytes are queued in a FIFO and shifted out LSB
// first with an elaboration-time character format and a run-time bit divisor.
//
// state    | meaning
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (line low)
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit (only reachable when PARITY != 0)
// S_STOP   | STOP_BITS stop bits (line high)
module rs232tx #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_LOG2 = 4,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] divisor,
   rs232tx_if.slave             bus,
   output logic                 serial_out
);

   localparam int                 DEPTH      = 1 << FIFO_LOG2;
   localparam logic [FIFO_LOG2:0] LEVEL_FULL = {1'b1, {FIFO_LOG2{1'b0}}};
   localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(2);
   localparam logic [2:0]         LAST_DATA  = 3'(DATA_BITS - 1);
   localparam logic [2:0]         LAST_STOP  = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr_q;
   logic [FIFO_LOG2-1:0] rd_ptr_q;
   logic [FIFO_LOG2:0]   level_q;
   logic                 overrun_q;

   state_t               state_q;
   logic                 serial_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 parity_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt_q;
   logic [2:0]           bit_q;

   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic                 last_stop;
   logic [DATA_BITS-1:0] head;
   logic                 head_par;
   logic [DIV_WIDTH-1:0] div_eff;

   assign full      = (level_q == LEVEL_FULL);
   assign push      = bus.we && !full;
   assign bit_end   = (cnt_q == '0);
   assign last_stop = (state_q == S_STOP) && bit_end && (bit_q == LAST_STOP);
   // A pop happens either from idle or on the very edge the last stop bit ends.
   assign pop       = (level_q != '0) && ((state_q == S_IDLE) || last_stop);
   assign head      = mem[rd_ptr_q];
   assign head_par  = (^head) ^ (PARITY == 1);
   assign div_eff   = (divisor < DIV_MIN) ? DIV_MIN : divisor;

   assign bus.full    = full;
   assign bus.level   = level_q;
   assign bus.overrun = overrun_q;
   assign bus.busy    = (state_q != S_IDLE) || (level_q != '0);
   assign serial_out  = serial_q;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.transmit_data[DATA_BITS-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (!push && pop) begin
            level_q <= level_q - 1'b1;
         end
         if (bus.we && full) begin
            overrun_q <= 1'b1;
         end else if (bus.clear_overrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         serial_q <= 1'b1;
         shift_q  <= '0;
         parity_q <= 1'b0;
         div_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
      end else if (pop) begin
         state_q  <= S_START;
         serial_q <= 1'b0;
         shift_q  <= head;
         parity_q <= head_par;
         div_q    <= div_eff;
         cnt_q    <= div_eff - DIV_ONE;
         bit_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               serial_q <= 1'b1;
            end
            S_START: begin
               if (bit_end) begin
                  state_q  <= S_DATA;
                  serial_q <= shift_q[0];
                  shift_q  <= shift_q >> 1;
                  cnt_q    <= div_q - DIV_ONE;
                  bit_q    <= '0;
               end else begin
                  cnt_q <= cnt_q - DIV_ONE;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt_q <= div_q - DIV_ONE;
                  if (bit_q == LAST_DATA) begin
                     bit_q <= '0;
                     if (PARITY != 0) begin
                        state_q  <= S_PARITY;
                        serial_q <= parity_q;
                     end else begin
                        state_q  <= S_STOP;
                        serial_q <= 1'b1;
                     end
                  end else begin
                     bit_q    <= bit_q + 3'd1;
                     serial_q <= shift_q[0];
                     shift_q  <= shift_q >> 1;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_ONE;
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  state_q  <= S_STOP;
                  serial_q <= 1'b1;
                  cnt_q    <= div_q - DIV_ONE;
                  bit_q    <= '0;
               end else begin
                  cnt_q <= cnt_q - DIV_ONE;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (bit_q == LAST_STOP) begin
                     state_q  <= S_IDLE;
                     serial_q <= 1'b1;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     cnt_q <= div_q - DIV_ONE;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_ONE;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               serial_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232tx.sv
// Bench for rs232tx: three instances with different character formats, each
// line compared cycle by cycle against a waveform built from the frame rules.
module tb_rs232tx;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic [15:0] div_a, div_b, div_c;
   logic        so_a, so_b, so_c;

   rs232tx_if #(.FIFO_LOG2(4)) bus_a ();
   rs232tx_if #(.FIFO_LOG2(2)) bus_b ();
   rs232tx_if #(.FIFO_LOG2(1)) bus_c ();

   // a: 8N1, 16 deep; b: 7E2, 4 deep; c: 5O1, 2 deep
   rs232tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_LOG2(4), .DIV_WIDTH(16))
      dut_a (.clock(clock), .reset_n(reset_n), .divisor(div_a), .bus(bus_a), .serial_out(so_a));
   rs232tx #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_LOG2(2), .DIV_WIDTH(16))
      dut_b (.clock(clock), .reset_n(reset_n), .divisor(div_b), .bus(bus_b), .serial_out(so_b));
   rs232tx #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(1), .FIFO_LOG2(1), .DIV_WIDTH(16))
      dut_c (.clock(clock), .reset_n(reset_n), .divisor(div_c), .bus(bus_c), .serial_out(so_c));

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_q[$];

   // Appends one whole frame, one entry per clock cycle, to the expected line.
   task automatic model_frame(input int b, input int d, input int dbits,
                              input int par, input int stops);
      int deff;
      int ones;
      int v;
      deff = (d < 2) ? 2 : d;
      ones = 0;
      for (int j = 0; j < deff; j++) exp_q.push_back(1'b0);
      for (int i = 0; i < dbits; i++) begin
         v = (b >> i) & 1;
         ones += v;
         for (int j = 0; j < deff; j++) exp_q.push_back(bit'(v));
      end
      if (par != 0) begin
         v = (par == 2) ? (ones % 2) : (1 - (ones % 2));
         for (int j = 0; j < deff; j++) exp_q.push_back(bit'(v));
      end
      for (int j = 0; j < stops * deff; j++) exp_q.push_back(1'b1);
   endtask

   task automatic drive(input int sel, input logic we, input logic [7:0] data);
      case (sel)
         0:       begin bus_a.we = we; bus_a.transmit_data = data; end
         1:       begin bus_b.we = we; bus_b.transmit_data = data; end
         default: begin bus_c.we = we; bus_c.transmit_data = data; end
      endcase
   endtask

   task automatic set_div(input int sel, input int d);
      case (sel)
         0:       div_a = 16'(d);
         1:       div_b = 16'(d);
         default: div_c = 16'(d);
      endcase
   endtask

   function automatic logic line_of(input int sel);
      return (sel == 0) ? so_a : (sel == 1) ? so_b : so_c;
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel == 0) ? bus_a.busy : (sel == 1) ? bus_b.busy : bus_c.busy;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(0, (i % 2) == 0, 8'($urandom));
         drive(1, (i % 2) == 1, 8'($urandom));
         drive(2, 1'b1, 8'($urandom));
         @(posedge clock); #1;
         n_cmp++;
         if ({so_a, bus_a.busy, bus_a.level, bus_a.full, bus_a.overrun} !== 9'b1_0_00000_0_0) begin
            n_bad++;
            $display("FAIL reset_a cyc=%0d: got line=%b busy=%b level=%0d full=%b ovr=%b want 1 0 0 0 0",
                     i, so_a, bus_a.busy, bus_a.level, bus_a.full, bus_a.overrun);
         end
         n_cmp++;
         if ({so_b, bus_b.busy, bus_b.level, bus_b.full, bus_b.overrun,
              so_c, bus_c.busy, bus_c.level, bus_c.full, bus_c.overrun} !== 14'b1_0_000_0_0_1_0_00_0_0) begin
            n_bad++;
            $display("FAIL reset_bc cyc=%0d: got b=%b%b%0d%b%b c=%b%b%0d%b%b want 10000 10000", i,
                     so_b, bus_b.busy, bus_b.level, bus_b.full, bus_b.overrun,
                     so_c, bus_c.busy, bus_c.level, bus_c.full, bus_c.overrun);
         end
      end
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      // First write is taken on the first rising edge after release.
      set_div(0, 2);
      drive(0, 1'b1, 8'hFF);
      exp_q.delete();
      model_frame(8'hFF, 2, 8, 0, 1);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      drive(0, 1'b0, 8'h00);
      n_cmp++;
      if (bus_a.level !== 5'd1) begin
         n_bad++;
         $display("FAIL reset_first_write: got level=%0d want 1", bus_a.level);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (so_a !== exp_q[k]) begin
            n_bad++;
            $display("FAIL reset_first_frame k=%0d: got %b want %b", k, so_a, exp_q[k]);
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic test_8n1();
      set_div(0, 4);
      exp_q.delete();
      model_frame(8'hA5, 4, 8, 0, 1);
      drive(0, 1'b1, 8'hA5);
      @(posedge clock); #1;
      drive(0, 1'b0, 8'h00);
      n_cmp++;
      if (bus_a.level !== 5'd1 || bus_a.busy !== 1'b1 || so_a !== 1'b1) begin
         n_bad++;
         $display("FAIL 8n1_e0: got level=%0d busy=%b line=%b want 1 1 1", bus_a.level, bus_a.busy, so_a);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (so_a !== exp_q[k] || bus_a.busy !== 1'b1 || (k == 0 && bus_a.level !== 5'd0)) begin
            n_bad++;
            $display("FAIL 8n1_line k=%0d: got line=%b busy=%b level=%0d want line=%b busy=1",
                     k, so_a, bus_a.busy, bus_a.level, exp_q[k]);
         end
      end
      @(posedge clock); #1;
      n_cmp++;
      if (bus_a.busy !== 1'b0 || so_a !== 1'b1) begin
         n_bad++;
         $display("FAIL 8n1_end: got busy=%b line=%b want 0 1", bus_a.busy, so_a);
      end
   endtask

   task automatic test_7e2();
      set_div(1, 3);
      exp_q.delete();
      model_frame(8'h53, 3, 7, 2, 2);
      drive(1, 1'b1, 8'h53);
      @(posedge clock); #1;
      drive(1, 1'b0, 8'h00);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (so_b !== exp_q[k]) begin
            n_bad++;
            $display("FAIL 7e2_line k=%0d: got %b want %b", k, so_b, exp_q[k]);
         end
      end
      @(posedge clock); #1;
      n_cmp++;
      if (bus_b.busy !== 1'b0 || so_b !== 1'b1) begin
         n_bad++;
         $display("FAIL 7e2_end: got busy=%b line=%b want 0 1", bus_b.busy, so_b);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      set_div(1, 2);
      exp_q.delete();
      for (int i = 1; i <= 5; i++) model_frame(i, 2, 7, 2, 2);
      n = exp_q.size();
      drive(1, 1'b1, 8'h01);
      @(posedge clock); #1;
      for (int c = 1; c <= n + 1; c++) begin
         if (c <= 4) drive(1, 1'b1, 8'(c + 1));
         else        drive(1, 1'b0, 8'h00);
         @(posedge clock); #1;
         if (c == 4) begin
            n_cmp++;
            if (bus_b.level !== 3'd4 || bus_b.full !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_peak: got level=%0d full=%b want 4 1", bus_b.level, bus_b.full);
            end
         end
         if (c <= n) begin
            n_cmp++;
            if (so_b !== exp_q[c-1] || bus_b.overrun !== 1'b0 || bus_b.busy !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_line c=%0d: got line=%b ovr=%b busy=%b want line=%b ovr=0 busy=1",
                        c, so_b, bus_b.overrun, bus_b.busy, exp_q[c-1]);
            end
         end else begin
            n_cmp++;
            if (bus_b.busy !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b_end: got busy=%b want 0", bus_b.busy);
            end
         end
      end
   endtask

   task automatic test_overrun();
      logic [7:0] w [6];
      int n;
      set_div(1, 2);
      exp_q.delete();
      model_frame(8'h11, 2, 7, 2, 2);
      for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) model_frame(w[i], 2, 7, 2, 2);
      n = exp_q.size();
      drive(1, 1'b1, 8'h11);
      @(posedge clock); #1;
      for (int c = 1; c <= n + 1; c++) begin
         if (c >= 4 && c <= 9) drive(1, 1'b1, w[c-4]);
         else if (c == 10)     drive(1, 1'b1, 8'($urandom));
         else                  drive(1, 1'b0, 8'h00);
         bus_b.clear_overrun = (c == 10) || (c == 11);
         @(posedge clock); #1;
         if (c == 7) begin
            n_cmp++;
            if (bus_b.level !== 3'd4 || bus_b.full !== 1'b1 || bus_b.overrun !== 1'b0) begin
               n_bad++;
               $display("FAIL ovr_fill: got level=%0d full=%b ovr=%b want 4 1 0",
                        bus_b.level, bus_b.full, bus_b.overrun);
            end
         end
         if (c >= 8 && c <= 10) begin
            n_cmp++;
            if (bus_b.overrun !== 1'b1 || bus_b.level !== 3'd4) begin
               n_bad++;
               $display("FAIL ovr_set c=%0d: got ovr=%b level=%0d want 1 4", c, bus_b.overrun, bus_b.level);
            end
         end
         if (c == 11) begin
            n_cmp++;
            if (bus_b.overrun !== 1'b0) begin
               n_bad++;
               $display("FAIL ovr_clear: got ovr=%b want 0", bus_b.overrun);
            end
         end
         if (c <= n) begin
            n_cmp++;
            if (so_b !== exp_q[c-1]) begin
               n_bad++;
               $display("FAIL ovr_line c=%0d: got %b want %b", c, so_b, exp_q[c-1]);
            end
         end else begin
            n_cmp++;
            if (bus_b.busy !== 1'b0 || bus_b.level !== 3'd0) begin
               n_bad++;
               $display("FAIL ovr_end: got busy=%b level=%0d want 0 0", bus_b.busy, bus_b.level);
            end
         end
      end
   endtask

   task automatic test_divisor_change();
      logic [7:0] b1, b2;
      int n;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      set_div(0, 4);
      exp_q.delete();
      model_frame(b1, 4, 8, 0, 1);
      model_frame(b2, 8, 8, 0, 1);
      n = exp_q.size();
      drive(0, 1'b1, b1);
      @(posedge clock); #1;
      for (int c = 1; c <= n + 1; c++) begin
         if (c == 1) drive(0, 1'b1, b2);
         else        drive(0, 1'b0, 8'h00);
         if (c == 10) set_div(0, 8);
         @(posedge clock); #1;
         n_cmp++;
         if (c <= n) begin
            if (so_a !== exp_q[c-1]) begin
               n_bad++;
               $display("FAIL divchg_line c=%0d: got %b want %b", c, so_a, exp_q[c-1]);
            end
         end else if (bus_a.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL divchg_end: got busy=%b want 0", bus_a.busy);
         end
      end
   endtask

   task automatic test_random(input int sel, input int dbits, input int par,
                              input int stops, input int nmax);
      logic [7:0] data [8];
      int n, d, len;
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(1, nmax);
         d = $urandom_range(0, 5);
         set_div(sel, d);
         exp_q.delete();
         for (int i = 0; i < n; i++) begin
            data[i] = 8'($urandom);
            model_frame(data[i], d, dbits, par, stops);
         end
         len = exp_q.size();
         drive(sel, 1'b1, data[0]);
         @(posedge clock); #1;
         for (int c = 1; c <= len + 1; c++) begin
            if (c < n) drive(sel, 1'b1, data[c]);
            else       drive(sel, 1'b0, 8'h00);
            @(posedge clock); #1;
            n_cmp++;
            if (c <= len) begin
               if (line_of(sel) !== exp_q[c-1]) begin
                  n_bad++;
                  $display("FAIL rand_line dut=%0d it=%0d div=%0d c=%0d: got %b want %b",
                           sel, it, d, c, line_of(sel), exp_q[c-1]);
               end
            end else if (busy_of(sel) !== 1'b0 || line_of(sel) !== 1'b1) begin
               n_bad++;
               $display("FAIL rand_end dut=%0d it=%0d: got busy=%b line=%b want 0 1",
                        sel, it, busy_of(sel), line_of(sel));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      set_div(0, 4);
      for (int c = 0; c < 10; c++) begin
         if (c < 4) drive(0, 1'b1, 8'($urandom));
         else       drive(0, 1'b0, 8'h00);
         @(posedge clock); #1;
      end
      n_cmp++;
      if (bus_a.level !== 5'd3 || bus_a.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_pre: got level=%0d busy=%b want 3 1", bus_a.level, bus_a.busy);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (so_a !== 1'b1 || bus_a.level !== 5'd0 || bus_a.busy !== 1'b0 || bus_a.full !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_async: got line=%b level=%0d busy=%b full=%b want 1 0 0 0",
                  so_a, bus_a.level, bus_a.busy, bus_a.full);
      end
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (so_a !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.level !== 5'd0) begin
            n_bad++;
            $display("FAIL rstmid_idle c=%0d: got line=%b busy=%b level=%0d want 1 0 0",
                     c, so_a, bus_a.busy, bus_a.level);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "time limit");
   end

   initial begin
      reset_n = 1'b0;
      div_a = 16'd4;
      div_b = 16'd2;
      div_c = 16'd2;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      bus_a.clear_overrun = 1'b0;
      bus_b.clear_overrun = 1'b0;
      bus_c.clear_overrun = 1'b0;
      test_reset();
      test_8n1();
      test_7e2();
      test_back_to_back();
      test_overrun();
      test_divisor_change();
      test_random(0, 8, 0, 1, 6);
      test_random(1, 7, 2, 2, 5);
      test_random(2, 5, 1, 1, 3);
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
